// File: rtl/mips_chk_pkg.sv
// Shared definitions for the MIPS run checker: FSM state encoding and the
// verdict codes reported on fail_code.
package mips_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RST  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_DATA    = 2'b01;
  localparam logic [1:0] FC_ADDR    = 2'b10;
  localparam logic [1:0] FC_TIMEOUT = 2'b11;

endpackage

// File: rtl/mips_chk_table.sv
// Expected-store table: N_CHECKS entries of {address, data}, one write port
// used while the checker is idle, one asynchronous read port addressed by the
// match pointer.
module mips_chk_table #(
  parameter int N_CHECKS = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [ADDR_W-1:0] wr_adr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ADDR_W-1:0] rd_adr,
  output logic [DATA_W-1:0] rd_data
);

  logic [ADDR_W-1:0] adr_mem  [N_CHECKS];
  logic [DATA_W-1:0] data_mem [N_CHECKS];
  logic              wr_ok;

  // Indices past the last entry are dropped rather than aliased.
  assign wr_ok = we && ({1'b0, wr_idx} < (IDX_W + 1)'(N_CHECKS));

  // Table write; contents must survive a checker reset so a run can be repeated.
  // NOTE: storage arrays carry no reset branch -- clearing them would both
  // destroy the programmed table and prevent mapping onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      adr_mem[wr_idx]  <= wr_adr;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_adr  = adr_mem[rd_idx];
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/mips_run_checker.sv
// Run controller/checker for the single-cycle MIPS core: holds the core in
// reset, releases it, then matches its stores against an ordered table of
// expected (address, data) pairs under a cycle watchdog.
module mips_run_checker #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int N_CHECKS     = 4,
  parameter int RESET_CYCLES = 4,
  parameter int TIMEOUT      = 1024,
  parameter int STRICT       = 1,
  // Derived widths; leave at their defaults.
  parameter int IDX_W        = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1,
  parameter int CNT_W        = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_adr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [IDX_W-1:0]  err_idx,
  output logic [CNT_W-1:0]  cycle_count
);

  import mips_chk_pkg::*;

  localparam int              RC_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(N_CHECKS - 1);
  localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_next;
  logic [RC_W-1:0]   rst_cnt;
  logic [IDX_W-1:0]  ptr;
  logic [ADDR_W-1:0] exp_adr;
  logic [DATA_W-1:0] exp_data;

  logic              adr_hit;
  logic              data_hit;
  logic              timeout_hit;
  logic              rst_entry;
  logic              verdict;
  logic              verdict_pass;
  logic [1:0]        verdict_code;
  logic              ptr_inc;

  mips_chk_table #(
    .N_CHECKS (N_CHECKS),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk     (clk),
    .we      (cfg_we && (state == ST_IDLE)),
    .wr_idx  (cfg_idx),
    .wr_adr  (cfg_adr),
    .wr_data (cfg_data),
    .rd_idx  (ptr),
    .rd_adr  (exp_adr),
    .rd_data (exp_data)
  );

  assign adr_hit     = (dataadr == exp_adr);
  assign data_hit    = (writedata == exp_data);
  // The watchdog fires on the RUN cycle that brings cycle_count to TIMEOUT.
  assign timeout_hit = (cycle_count == CNT_LAST);
  assign rst_entry   = (state_next == ST_RST) && (state != ST_RST);

  // Core is held in reset everywhere except while the program is running.
  assign cpu_reset = (state != ST_RUN);
  assign busy      = (state == ST_RST) || (state == ST_RUN);
  assign done      = (state == ST_DONE);

  // State register.
  // NOTE: every clocked block assigns with <= so all flops sample the values
  // present before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and verdict decode; store compare priority: final match,
  // data mismatch, address mismatch, then timeout.
  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next   = state;
    verdict      = 1'b0;
    verdict_pass = 1'b0;
    verdict_code = FC_NONE;
    ptr_inc      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RST;
      end
      ST_RST: begin
        if (rst_cnt == RST_LAST) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (memwrite && adr_hit && data_hit) begin
          if (ptr == PTR_LAST) begin
            verdict      = 1'b1;
            verdict_pass = 1'b1;
          end else begin
            ptr_inc = 1'b1;
          end
        end else if (memwrite && adr_hit) begin
          verdict      = 1'b1;
          verdict_code = FC_DATA;
        end else if (memwrite && (STRICT != 0)) begin
          verdict      = 1'b1;
          verdict_code = FC_ADDR;
        end
        if (!verdict && timeout_hit) begin
          verdict      = 1'b1;
          verdict_code = FC_TIMEOUT;
        end
        if (verdict) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start) state_next = ST_RST;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Counters, match pointer and latched verdict; all cleared when a run begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_cnt     <= '0;
      ptr         <= '0;
      cycle_count <= '0;
      pass        <= 1'b0;
      fail_code   <= FC_NONE;
      err_idx     <= '0;
    end else if (rst_entry) begin
      rst_cnt     <= '0;
      ptr         <= '0;
      cycle_count <= '0;
      pass        <= 1'b0;
      fail_code   <= FC_NONE;
      err_idx     <= '0;
    end else begin
      if (state == ST_RST) rst_cnt <= rst_cnt + 1'b1;
      if (state == ST_RUN) begin
        if (cycle_count != CNT_MAX) cycle_count <= cycle_count + 1'b1;
        if (ptr_inc) ptr <= ptr + 1'b1;
        if (verdict) begin
          pass      <= verdict_pass;
          fail_code <= verdict_code;
          err_idx   <= verdict_pass ? '0 : ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_run_checker.sv
// Self-checking bench for mips_run_checker: a strict and a non-strict
// instance see the same stimulus; expected verdicts are queued per run and
// compared when each instance reports done.
module tb_mips_run_checker;

  import mips_chk_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int N  = 4;
  localparam int RC = 4;
  localparam int TO = 16;
  localparam int IW = 2;
  localparam int CW = $clog2(TO + 1);

  typedef struct {
    logic          pass;
    logic [1:0]    code;
    logic [IW-1:0] err;
    int            cyc;
  } verdict_t;

  logic          clk = 1'b0;
  logic          reset, cfg_we, start, memwrite;
  logic [IW-1:0] cfg_idx;
  logic [AW-1:0] cfg_adr, dataadr;
  logic [DW-1:0] cfg_data, writedata;

  logic          s_cpu_reset, s_busy, s_done, s_pass;
  logic [1:0]    s_fail_code;
  logic [IW-1:0] s_err_idx;
  logic [CW-1:0] s_cycle_count;
  logic          l_cpu_reset, l_busy, l_done, l_pass;
  logic [1:0]    l_fail_code;
  logic [IW-1:0] l_err_idx;
  logic [CW-1:0] l_cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  verdict_t q_s[$];
  verdict_t q_l[$];

  int          st_cyc [8];
  logic [31:0] st_adr [8];
  logic [31:0] st_dat [8];
  int          n_st;

  always #5 clk = ~clk;

  mips_run_checker #(
    .DATA_W(DW), .ADDR_W(AW), .N_CHECKS(N), .RESET_CYCLES(RC), .TIMEOUT(TO), .STRICT(1)
  ) u_strict (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
    .cfg_data(cfg_data), .start(start), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .cpu_reset(s_cpu_reset), .busy(s_busy), .done(s_done),
    .pass(s_pass), .fail_code(s_fail_code), .err_idx(s_err_idx), .cycle_count(s_cycle_count)
  );

  mips_run_checker #(
    .DATA_W(DW), .ADDR_W(AW), .N_CHECKS(N), .RESET_CYCLES(RC), .TIMEOUT(TO), .STRICT(0)
  ) u_loose (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
    .cfg_data(cfg_data), .start(start), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .cpu_reset(l_cpu_reset), .busy(l_busy), .done(l_done),
    .pass(l_pass), .fail_code(l_fail_code), .err_idx(l_err_idx), .cycle_count(l_cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic verdict_t mk(input logic p, input logic [1:0] c, input int e, input int cy);
    verdict_t v;
    v.pass = p;
    v.code = c;
    v.err  = IW'(e);
    v.cyc  = cy;
    return v;
  endfunction

  task automatic clear_st();
    n_st = 0;
  endtask

  task automatic add_st(input int cyc, input logic [31:0] adr, input logic [31:0] dat);
    st_cyc[n_st] = cyc;
    st_adr[n_st] = adr;
    st_dat[n_st] = dat;
    n_st++;
  endtask

  task automatic cfg(input int idx, input logic [31:0] adr, input logic [31:0] dat);
    cfg_we   = 1'b1;
    cfg_idx  = IW'(idx);
    cfg_adr  = adr;
    cfg_data = dat;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_cpu_reset"}, s_cpu_reset, 1);
    check({tag, "_busy"}, s_busy, 0);
    check({tag, "_done"}, s_done, 0);
    check({tag, "_pass"}, s_pass, 0);
    check({tag, "_code"}, s_fail_code, FC_NONE);
    check({tag, "_err"}, s_err_idx, 0);
    check({tag, "_cycles"}, s_cycle_count, 0);
  endtask

  // Pulse start, measure the core-reset window, then play the store list by
  // RUN-cycle number. inj_cyc: RUN cycle carrying a stray start + cfg write.
  // abort_cyc: RUN cycle carrying a checker reset.
  task automatic run(input int inj_cyc, input int abort_cyc);
    int       rcnt;
    bit       got_s, got_l;
    verdict_t e;
    start = 1'b1;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    rcnt = 0;
    while (s_busy && s_cpu_reset && rcnt < 20) begin
      rcnt++;
      tick();
    end
    check("rst_len", rcnt, RC);
    check("run_cpu_reset", s_cpu_reset, 0);
    check("run_busy", s_busy, 1);
    got_s = 1'b0;
    got_l = 1'b0;
    for (int c = 1; c <= 40 && !(got_s && got_l); c++) begin
      memwrite = 1'b0;
      for (int i = 0; i < n_st; i++) begin
        if (st_cyc[i] == c) begin
          memwrite  = 1'b1;
          dataadr   = st_adr[i];
          writedata = st_dat[i];
        end
      end
      if (c == inj_cyc) begin
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_idx  = IW'(3);
        cfg_adr  = 32'h99;
        cfg_data = 32'h0;
      end
      if (c == abort_cyc) reset = 1'b1;
      tick();
      memwrite = 1'b0;
      start    = 1'b0;
      cfg_we   = 1'b0;
      if (c == abort_cyc) begin
        reset = 1'b0;
        check_cleared("abort");
        return;
      end
      if (s_done && !got_s) begin
        got_s = 1'b1;
        if (q_s.size() == 0) check("s_sb_empty", 1, 0);
        else begin
          e = q_s.pop_front();
          check("s_pass", s_pass, e.pass);
          check("s_code", s_fail_code, e.code);
          check("s_err", s_err_idx, e.err);
          check("s_cyc", c, e.cyc);
        end
      end
      if (l_done && !got_l) begin
        got_l = 1'b1;
        if (q_l.size() == 0) check("l_sb_empty", 1, 0);
        else begin
          e = q_l.pop_front();
          check("l_pass", l_pass, e.pass);
          check("l_code", l_fail_code, e.code);
          check("l_err", l_err_idx, e.err);
          check("l_cyc", c, e.cyc);
        end
      end
    end
    if (!got_s) begin
      check("s_watchdog", got_s, 1);
      if (q_s.size() != 0) void'(q_s.pop_front());
    end
    if (!got_l) begin
      check("l_watchdog", got_l, 1);
      if (q_l.size() != 0) void'(q_l.pop_front());
    end
  endtask

  task automatic expect_both(input verdict_t v);
    q_s.push_back(v);
    q_l.push_back(v);
  endtask

  task automatic golden_stores();
    clear_st();
    add_st(1, 32'h54, 32'd7);
    add_st(2, 32'h50, 32'd7);
    add_st(3, 32'h54, 32'd3);
    add_st(4, 32'h58, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    reset     = 1'b1;
    cfg_we    = 1'b0;
    cfg_idx   = '0;
    cfg_adr   = '0;
    cfg_data  = '0;
    start     = 1'b0;
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
    n_st      = 0;
    repeat (2) tick();
    check_cleared("reset");
    reset = 1'b0;

    // Table load; the last write shares its cycle with start.
    cfg(0, 32'h54, 32'd7);
    cfg(1, 32'h50, 32'd7);
    cfg(2, 32'h54, 32'd3);
    cfg_we   = 1'b1;
    cfg_idx  = IW'(3);
    cfg_adr  = 32'h58;
    cfg_data = 32'd1;

    // T1: in-order stores with gaps, verdict one cycle after the 4th store.
    clear_st();
    add_st(1, 32'h54, 32'd7);
    add_st(3, 32'h50, 32'd7);
    add_st(5, 32'h54, 32'd3);
    add_st(7, 32'h58, 32'd1);
    expect_both(mk(1'b1, FC_NONE, 0, 7));
    run(0, 0);
    check("t1_cycles", s_cycle_count, 7);
    check("t1_done_cpu_reset", s_cpu_reset, 1);
    repeat (2) tick();
    check("t1_cycles_frozen", s_cycle_count, 7);
    check("t1_done_held", s_done, 1);

    // T2: third store carries wrong data.
    clear_st();
    add_st(1, 32'h54, 32'd7);
    add_st(2, 32'h50, 32'd7);
    add_st(3, 32'h54, 32'd4);
    expect_both(mk(1'b0, FC_DATA, 2, 3));
    run(0, 0);
    check("t2_cpu_reset", s_cpu_reset, 1);

    // T3: stray store to 0x60 before entry 1.
    clear_st();
    add_st(1, 32'h54, 32'd7);
    add_st(2, 32'h60, 32'd9);
    add_st(3, 32'h50, 32'd7);
    add_st(4, 32'h54, 32'd3);
    add_st(5, 32'h58, 32'd1);
    q_s.push_back(mk(1'b0, FC_ADDR, 1, 2));
    q_l.push_back(mk(1'b1, FC_NONE, 0, 5));
    run(0, 0);

    // T4a: no stores at all -> watchdog.
    clear_st();
    expect_both(mk(1'b0, FC_TIMEOUT, 0, TO));
    run(0, 0);
    check("t4_cycles", s_cycle_count, TO);

    // T4b: final match lands on the watchdog cycle -> pass.
    clear_st();
    add_st(1, 32'h54, 32'd7);
    add_st(2, 32'h50, 32'd7);
    add_st(3, 32'h54, 32'd3);
    add_st(TO, 32'h58, 32'd1);
    expect_both(mk(1'b1, FC_NONE, 0, TO));
    run(0, 0);

    // T5: start and a table write during RUN must both be ignored.
    clear_st();
    add_st(1, 32'h54, 32'd7);
    add_st(4, 32'h50, 32'd7);
    add_st(5, 32'h54, 32'd3);
    add_st(6, 32'h58, 32'd1);
    expect_both(mk(1'b1, FC_NONE, 0, 6));
    run(2, 0);

    // T6: reset mid-run, then re-run the retained table.
    clear_st();
    add_st(1, 32'h54, 32'd7);
    run(0, 3);
    golden_stores();
    expect_both(mk(1'b1, FC_NONE, 0, 4));
    run(0, 0);

    check("sb_drained", q_s.size() + q_l.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
